// File: rtl/dual_issue_fetch_queue.sv
// Fetch-side instruction queue for the dual-issue scheduler: fixed 1-cycle imem, circular FIFO, 0/1/2 retire.
// Optional FETCH_HALT_EN: stop fetching once an EBREAK word has been queued (adds `halted` output).
module dual_issue_fetch_queue #(
    parameter int unsigned DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      imem_req,
    output logic [31:0]               imem_addr,
    input  logic [31:0]               imem_rdata,
    input  logic                      flush,
    input  logic [31:0]               flush_pc,
    input  logic                      freeze1,
    input  logic                      freeze2,
    output logic [31:0]               instruction0,
    output logic [31:0]               instruction1,
    output logic                      nothing_filled,
    output logic [$clog2(DEPTH):0]    count
`ifdef FETCH_HALT_EN
    ,
    output logic                      halted
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [31:0]   pc_q, pc_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          inflight_q, inflight_d;
    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   mem_d [DEPTH];

    logic          push, pop0, pop1, space_ok, halt_block;
    logic [PW-1:0] rd_ptr_p1;

`ifdef FETCH_HALT_EN
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    logic halted_q, halted_d;

    // The returning EBREAK also blocks the request in its own cycle, so no fetch past it is issued.
    assign halt_block = halted_q || (inflight_q && (imem_rdata == EBREAK));
    assign halted     = halted_q;
`else
    assign halt_block = 1'b0;
`endif

    // The in-flight word is reserved space, so a push can never find the FIFO full.
    assign space_ok = ({1'b0, count_q} + {{CW{1'b0}}, inflight_q}) < (CW + 1)'(DEPTH);

    always_comb begin
        push     = inflight_q;
        pop0     = !freeze1 && (count_q != '0);
        pop1     = pop0 && !freeze2 && (count_q >= CW'(2));
        imem_req = !rst && !flush && space_ok && !halt_block;

        pc_d       = pc_q;
        rd_ptr_d   = rd_ptr_q + PW'(pop0) + PW'(pop1);
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q + CW'(push) - CW'(pop0) - CW'(pop1);
        inflight_d = imem_req;
        mem_d      = mem_q;
`ifdef FETCH_HALT_EN
        halted_d   = halted_q;
`endif

        if (push) begin
            mem_d[wr_ptr_q] = imem_rdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
`ifdef FETCH_HALT_EN
            if (imem_rdata == EBREAK) halted_d = 1'b1;
`endif
        end
        if (imem_req) pc_d = pc_q + 32'd4;

        if (flush) begin
            pc_d       = flush_pc & 32'hFFFF_FFFC;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            inflight_d = 1'b0;
`ifdef FETCH_HALT_EN
            halted_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
`ifdef FETCH_HALT_EN
            halted_q   <= 1'b0;
`endif
        end else begin
            pc_q       <= pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
`ifdef FETCH_HALT_EN
            halted_q   <= halted_d;
`endif
        end
    end

    // Storage needs no reset: every read is masked by count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_ptr_p1      = rd_ptr_q + 1'b1;
    assign imem_addr      = pc_q;
    assign count          = count_q;
    assign nothing_filled = (count_q == '0);
    assign instruction0   = (count_q != '0)      ? mem_q[rd_ptr_q]  : '0;
    assign instruction1   = (count_q >= CW'(2))  ? mem_q[rd_ptr_p1] : '0;

endmodule
